// File: rtl/stopwatch_controller.sv
// Stopwatch sequencing controller: button sync/debounce, run/pause/lap/clear FSM, ms tick gating.
// Define STOPWATCH_DEBOUNCE_EN to include the per-button debounce filter.
module stopwatch_controller #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ms_tick,
    input  logic       btn_start_stop_n,
    input  logic       btn_lap_n,
    input  logic       btn_clear_n,
    output logic       ms_enable,
    output logic       counter_clear,
    output logic       lap_hold,
    output logic       running,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    // Bit 0 start/stop, bit 1 lap, bit 2 clear; all levels active-low.
    logic [2:0] raw_level;
    logic [2:0] sync_meta;
    logic [2:0] sync_level;
    logic [2:0] accepted;
    logic [2:0] accepted_d;
    logic [2:0] press;

    assign raw_level = {btn_clear_n, btn_lap_n, btn_start_stop_n};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta  <= 3'b111;
            sync_level <= 3'b111;
        end else begin
            sync_meta  <= raw_level;
            sync_level <= sync_meta;
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    // The level flips on the DEBOUNCE_CYCLES-th consecutive differing cycle.
    for (genvar b = 0; b < 3; b++) begin : g_debounce
        logic [CW-1:0] count;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                count       <= '0;
                accepted[b] <= 1'b1;
            end else if (sync_level[b] == accepted[b]) begin
                count <= '0;
            end else if (count == LAST_COUNT) begin
                count       <= '0;
                accepted[b] <= sync_level[b];
            end else begin
                count <= count + CW'(1);
            end
        end
    end
`else
    assign accepted = sync_level;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            accepted_d <= 3'b111;
        end else begin
            accepted_d <= accepted;
        end
    end

    assign press = accepted_d & ~accepted;

    // Clear outranks start/stop, which outranks lap; losers are dropped.
    logic ev_clear;
    logic ev_start_stop;
    logic ev_lap;

    assign ev_clear      = press[2];
    assign ev_start_stop = press[0] & ~press[2];
    assign ev_lap        = press[1] & ~press[2] & ~press[0];

    state_t state_q;
    state_t state_next;
    logic   clear_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            counter_clear <= 1'b0;
            ms_enable     <= 1'b0;
        end else begin
            state_q       <= state_next;
            counter_clear <= clear_next;
            ms_enable     <= ms_tick & running;
        end
    end

    always_comb begin
        state_next = state_q;
        clear_next = 1'b0;
        case (state_q)
            IDLE: begin
                if (ev_clear) begin
                    clear_next = 1'b1;
                end else if (ev_start_stop) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (ev_start_stop) begin
                    state_next = PAUSE;
                end else if (ev_lap) begin
                    state_next = LAP;
                end
            end
            LAP: begin
                if (ev_start_stop) begin
                    state_next = PAUSE;
                end else if (ev_lap) begin
                    state_next = RUN;
                end
            end
            PAUSE: begin
                if (ev_clear) begin
                    state_next = IDLE;
                    clear_next = 1'b1;
                end else if (ev_start_stop) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign running  = (state_q == RUN) || (state_q == LAP);
    assign lap_hold = (state_q == LAP);
    assign state    = state_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed self-checking bench for stopwatch_controller (DEBOUNCE_CYCLES = 4).
// Expectations adapt to whether STOPWATCH_DEBOUNCE_EN is defined.
module tb_stopwatch_controller;

    localparam int D = 4;
`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int LAT = D + 3;
`else
    localparam int LAT = 3;
`endif

    logic       clock;
    logic       reset;
    logic       ms_tick;
    logic       btn_start_stop_n;
    logic       btn_lap_n;
    logic       btn_clear_n;
    logic       ms_enable;
    logic       counter_clear;
    logic       lap_hold;
    logic       running;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    stopwatch_controller #(.DEBOUNCE_CYCLES(D)) dut (
        .clock           (clock),
        .reset           (reset),
        .ms_tick         (ms_tick),
        .btn_start_stop_n(btn_start_stop_n),
        .btn_lap_n       (btn_lap_n),
        .btn_clear_n     (btn_clear_n),
        .ms_enable       (ms_enable),
        .counter_clear   (counter_clear),
        .lap_hold        (lap_hold),
        .running         (running),
        .state           (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic check_state(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_btn(input int which, input logic level);
        case (which)
            0: btn_start_stop_n = level;
            1: btn_lap_n        = level;
            default: btn_clear_n = level;
        endcase
    endtask

    // Leaves the button held and returns just after the edge that updates state.
    task automatic press_begin(input int which, input logic tick);
        drive_btn(which, 1'b0);
        step(LAT - 1);
        ms_tick = tick;
        step(1);
        ms_tick = 1'b0;
    endtask

    task automatic release_btn(input int which);
        step(2);
        drive_btn(which, 1'b1);
        step(LAT + 2);
    endtask

    task automatic tick_once;
        ms_tick = 1'b1;
        step(1);
        ms_tick = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        ms_tick          = 1'b0;
        btn_start_stop_n = 1'b1;
        btn_lap_n        = 1'b1;
        btn_clear_n      = 1'b1;
        step(3);
        check_state("reset_state", state, 2'b00);
        check_bit("reset_ms_enable", ms_enable, 1'b0);
        check_bit("reset_counter_clear", counter_clear, 1'b0);
        check_bit("reset_lap_hold", lap_hold, 1'b0);
        check_bit("reset_running", running, 1'b0);
        reset = 1'b0;
        step(2);

        tick_once();
        check_bit("idle_tick_blocked", ms_enable, 1'b0);

        // First start press: exact latency, then held button gives one event.
        drive_btn(0, 1'b0);
        step(LAT - 1);
        check_state("ss_latency_early", state, 2'b00);
        step(1);
        check_state("ss_latency", state, 2'b01);
        check_bit("run_running", running, 1'b1);
        step(10 - LAT);
        drive_btn(0, 1'b1);
        step(LAT + 2);
        check_state("held_one_event", state, 2'b01);

        for (int i = 0; i < 2; i++) begin
            tick_once();
            check_bit("run_tick_pass", ms_enable, 1'b1);
            step(1);
            check_bit("run_tick_width", ms_enable, 1'b0);
            step(3);
        end

        press_begin(0, 1'b1);
        check_state("run_to_pause", state, 2'b10);
        check_bit("tick_on_pause_edge", ms_enable, 1'b1);
        release_btn(0);
        tick_once();
        check_bit("pause_tick_blocked", ms_enable, 1'b0);

        press_begin(0, 1'b1);
        check_state("pause_to_run", state, 2'b01);
        check_bit("tick_on_run_edge", ms_enable, 1'b0);
        release_btn(0);

        press_begin(1, 1'b0);
        check_state("run_to_lap", state, 2'b11);
        check_bit("lap_hold_set", lap_hold, 1'b1);
        check_bit("lap_running", running, 1'b1);
        release_btn(1);
        tick_once();
        check_bit("lap_tick_pass", ms_enable, 1'b1);

        press_begin(1, 1'b0);
        check_state("lap_to_run", state, 2'b01);
        check_bit("lap_hold_clear", lap_hold, 1'b0);
        release_btn(1);

        press_begin(1, 1'b0);
        check_state("run_to_lap_again", state, 2'b11);
        release_btn(1);
        press_begin(0, 1'b0);
        check_state("lap_to_pause", state, 2'b10);
        check_bit("lap_pause_hold", lap_hold, 1'b0);
        check_bit("pause_running", running, 1'b0);
        release_btn(0);

        press_begin(0, 1'b0);
        release_btn(0);
        press_begin(2, 1'b0);
        check_state("clear_in_run_ignored", state, 2'b01);
        check_bit("clear_in_run_no_pulse", counter_clear, 1'b0);
        release_btn(2);

        press_begin(0, 1'b0);
        check_state("run_to_pause_b", state, 2'b10);
        release_btn(0);
        press_begin(2, 1'b0);
        check_state("clear_in_pause", state, 2'b00);
        check_bit("clear_pulse", counter_clear, 1'b1);
        step(1);
        check_bit("clear_pulse_width", counter_clear, 1'b0);
        release_btn(2);

        press_begin(1, 1'b0);
        check_state("lap_in_idle_ignored", state, 2'b00);
        release_btn(1);

        press_begin(2, 1'b0);
        check_state("clear_in_idle", state, 2'b00);
        check_bit("clear_in_idle_pulse", counter_clear, 1'b1);
        release_btn(2);

        // Clear and start/stop accepted together from PAUSE.
        press_begin(0, 1'b0);
        release_btn(0);
        press_begin(0, 1'b0);
        release_btn(0);
        check_state("prio_setup_pause", state, 2'b10);
        drive_btn(0, 1'b0);
        drive_btn(2, 1'b0);
        step(LAT);
        check_state("prio_clear_wins", state, 2'b00);
        check_bit("prio_clear_pulse", counter_clear, 1'b1);
        step(2);
        drive_btn(0, 1'b1);
        drive_btn(2, 1'b1);
        step(LAT + 2);
        check_state("prio_settled", state, 2'b00);

`ifdef STOPWATCH_DEBOUNCE_EN
        for (int i = 0; i < 10; i++) begin
            drive_btn(0, logic'(i % 2));
            step(3);
        end
        drive_btn(0, 1'b1);
        step(LAT + 2);
        check_state("bounce_rejected", state, 2'b00);
        drive_btn(0, 1'b0);
        step(10);
        check_state("after_bounce_press", state, 2'b01);
        drive_btn(0, 1'b1);
        step(LAT + 2);
        check_state("after_bounce_single", state, 2'b01);
`else
        drive_btn(0, 1'b0);
        step(1);
        drive_btn(0, 1'b1);
        step(LAT - 1);
        check_state("glitch_accepted", state, 2'b01);
        step(LAT + 2);
        check_state("glitch_single", state, 2'b01);
`endif

        // Asynchronous reset while running with ms_enable high.
        tick_once();
        check_bit("pre_reset_enable", ms_enable, 1'b1);
        reset = 1'b1;
        #1;
        check_state("async_reset_state", state, 2'b00);
        check_bit("async_reset_enable", ms_enable, 1'b0);
        check_bit("async_reset_running", running, 1'b0);
        step(1);
        reset = 1'b0;
        step(2);
        tick_once();
        check_bit("post_reset_tick_blocked", ms_enable, 1'b0);
        check_bit("post_reset_no_clear", counter_clear, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
